product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//   Downstream stage of the 2x2 array multiplier. Consumes its 4-bit products
//   over a valid/ready handshake and sums a frame of COUNT products into a wider
//   accumulator. Presents each frame total on an output valid/ready handshake.
//   Used for dot-product / multiply-accumulate sequences built on the multiplier.
// PARAMETERS
//   PROD_W  4  product width; matches multiplier output C[3:0]
//   ACC_W   8  accumulator / out_sum width; must be >= PROD_W
//   COUNT   4  products per frame; must be >= 1
// PORTS
//   clk       in   1       single clock; all state on rising edge
//   rst_n     in   1       asynchronous, active-low reset
//   clear     in   1       synchronous abort of current frame
//   in_valid  in   1       in_prod is valid this cycle
//   in_ready  out  1       block accepts a product this cycle
//   in_prod   in   PROD_W  product from multiplier; unsigned
//   out_valid out  1       out_sum/out_ovf hold a completed frame
//   out_ready in   1       consumer accepts the frame result
//   out_sum   out  ACC_W   frame total
//   out_ovf   out  1       frame total exceeded 2^ACC_W-1
// BEHAVIOUR
//   Reset (rst_n=0, async): state=ACCUM, acc=0, cnt=0; out_valid=0, out_sum=0, out_ovf=0.
//     Registered outputs take these values immediately; in_ready is 1 once out of reset.
//   FSM states:
//   - ACCUM: in_ready=1, out_valid=0.
//     Accept when in_valid&&in_ready: acc <= acc + zext(in_prod) (ACC_W+1-bit add), cnt <= cnt+1.
//     Carry out of ACC_W sets the sticky ovf flag for the frame.
//     Accept with cnt==COUNT-1: out_sum <= final sum, out_ovf <= sticky|carry,
//     out_valid <= 1, go to HOLD. Result is visible 1 cycle after the last accept.
//   - HOLD: in_ready=0; out_valid=1; out_sum/out_ovf stable while out_ready=0.
//     out_valid&&out_ready: acc=0, cnt=0, sticky=0, out_valid <= 0, go to ACCUM.
//     The next product is accepted no earlier than the cycle after the handshake;
//     there is no bypass.
//   - No input is dropped: a product is consumed only on in_valid&&in_ready.
//     in_prod is ignored while in_valid=0.
//   - clear=1 takes priority over all handshakes in any state:
//     acc, cnt and sticky are zeroed; out_valid <= 0; go to ACCUM.
//     A product presented in that same cycle is NOT accumulated.
//     out_sum/out_ovf keep their last values.
//   - COUNT=1: every accepted product goes directly to HOLD.
//   - cnt width is $clog2(COUNT+1); cnt never exceeds COUNT-1 in ACCUM.
//   - rst_n asserted mid-frame or in HOLD discards everything and returns to reset values.
// CONFIGURATION
//   PRODUCT_ACC_SAT_EN defined: on a carry out of ACC_W, acc clamps to {ACC_W{1'b1}}
//     and stays there for the rest of the frame; out_ovf=1.
//   PRODUCT_ACC_SAT_EN undefined: acc wraps modulo 2^ACC_W; out_ovf still reports the wrap.
// TESTING
//   Default params; products 9,9,9,9 back-to-back, out_ready=1
//     -> out_sum=36, out_ovf=0, out_valid 1 cycle after 4th accept.
//   Default params; frame completes with out_ready=0 for 5 cycles
//     -> in_ready=0 and out_sum=36 held stable for all 5 cycles;
//        handshake on cycle 6, then in_ready=1.
//   ACC_W=5, products 9,9,9,9, macro undefined -> out_sum=4, out_ovf=1.
//   Same stimulus with PRODUCT_ACC_SAT_EN defined -> out_sum=31, out_ovf=1.
//   Products 6,4, then clear=1 with in_valid=1, in_prod=2, then 1,1,1,1
//     -> out_sum=4 (the 2 is discarded).
//   rst_n pulsed low after 2 accepts; then 3,3,3,3
//     -> outputs 0 during reset, then out_sum=12.
//   In-frame idle gaps (in_valid=0) between 1,2,3,4 -> out_sum=10.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator: sums frames of COUNT unsigned products; presents each total over valid/ready.
// Define PRODUCT_ACC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module product_accumulator #(
  parameter int PROD_W = 4,
  parameter int ACC_W  = 8,
  parameter int COUNT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);
  localparam int CW = $clog2(COUNT + 1);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t           state;
  logic [ACC_W-1:0] acc, acc_next;
  logic [ACC_W:0]   wide;
  logic [CW-1:0]    cnt;
  logic             sticky, carry, last;
  always_comb begin
    wide = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    carry = wide[ACC_W];
`ifdef PRODUCT_ACC_SAT_EN
    acc_next = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    acc_next = wide[ACC_W-1:0];
`endif
    last = cnt == CW'(COUNT - 1);
  end
  assign in_ready = state == ACCUM;
  // clear outranks every handshake; out_sum/out_ovf deliberately survive it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (clear || (state == HOLD && out_ready)) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
    end else if (state == ACCUM && in_valid) begin
      acc    <= acc_next;
      sticky <= sticky | carry;
      cnt    <= cnt + CW'(1);
      if (last) begin
        out_sum   <= acc_next;
        out_ovf   <= sticky | carry;
        out_valid <= 1'b1;
        state     <= HOLD;
      end
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: table-driven frame vectors plus stall, clear and reset sequences.
// Runs a default DUT and an ACC_W=5 DUT side by side on the same stimulus.
module tb_product_accumulator;
  logic       clk = 0, rst_n = 0, clear = 0, in_valid = 0, out_ready = 0;
  logic [3:0] in_prod = 0;
  logic       in_ready, out_valid, out_ovf, in_ready5, out_valid5, out_ovf5;
  logic [7:0] out_sum;
  logic [4:0] out_sum5;
  int errors = 0, checks = 0;
`ifdef PRODUCT_ACC_SAT_EN
  localparam bit SAT = 1;
`else
  localparam bit SAT = 0;
`endif

  product_accumulator dut (.clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .in_prod(in_prod), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf));
  product_accumulator #(.ACC_W(5)) dut5 (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready5), .in_prod(in_prod), .out_valid(out_valid5),
    .out_ready(out_ready), .out_sum(out_sum5), .out_ovf(out_ovf5));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p;
    int          gap;
    logic [7:0]  sum;
    logic        ovf;
    logic [4:0]  sum5w, sum5s;
    logic        ovf5;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [3:0] p);
    int n = 0;
    in_valid = 1;
    in_prod = p;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("send_timeout", 1, 0);
    @(negedge clk);
    in_valid = 0;
    in_prod = 4'hF;
  endtask

  task automatic take(input string name);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({name, "_valid_drop"}, out_valid, 0);
    chk({name, "_in_ready"}, in_ready, 1);
  endtask

  task automatic expect_res(input string name, input int s, input int o, input int s5, input int o5);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_valid5"}, out_valid5, 1);
    chk({name, "_sum"}, out_sum, s);
    chk({name, "_ovf"}, out_ovf, o);
    chk({name, "_sum5"}, out_sum5, s5);
    chk({name, "_ovf5"}, out_ovf5, o5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h9999, 0, 8'd36, 1'b0, 5'd4,  5'd31, 1'b1};
    vecs[1] = '{16'h4321, 2, 8'd10, 1'b0, 5'd10, 5'd10, 1'b0};
    vecs[2] = '{16'hFFFF, 0, 8'd60, 1'b0, 5'd28, 5'd31, 1'b1};
    vecs[3] = '{16'h0000, 1, 8'd0,  1'b0, 5'd0,  5'd0,  1'b0};
    vecs[4] = '{16'h01FF, 0, 8'd31, 1'b0, 5'd31, 5'd31, 1'b0};
    vecs[5] = '{16'h02FF, 3, 8'd32, 1'b0, 5'd0,  5'd31, 1'b1};

    #2;
    chk("reset_valid", out_valid, 0);
    chk("reset_sum", out_sum, 0);
    chk("reset_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("after_reset_in_ready", in_ready, 1);

    foreach (vecs[v]) begin
      for (int i = 0; i < 4; i++) begin
        repeat (vecs[v].gap) @(negedge clk);
        send(vecs[v].p[4*i +: 4]);
        if (i < 3) chk($sformatf("v%0d_early_valid", v), out_valid, 0);
      end
      expect_res($sformatf("v%0d", v), vecs[v].sum, vecs[v].ovf,
                 SAT ? vecs[v].sum5s : vecs[v].sum5w, vecs[v].ovf5);
      take($sformatf("v%0d", v));
    end

    // 5-cycle backpressure on a 9,9,9,9 frame
    for (int i = 0; i < 4; i++) send(4'd9);
    for (int c = 0; c < 5; c++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_sum", out_sum, 36);
      in_valid = 1;
      in_prod = 4'd7;
      @(negedge clk);
    end
    in_valid = 0;
    take("stall");

    // clear mid-frame drops the product offered alongside it
    send(4'd6);
    send(4'd4);
    clear = 1;
    in_valid = 1;
    in_prod = 4'd2;
    @(negedge clk);
    clear = 0;
    in_valid = 0;
    chk("clear_keeps_sum", out_sum, 36);
    chk("clear_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) send(4'd1);
    expect_res("clear", 4, 0, 4, 0);

    // clear while holding a result
    clear = 1;
    @(negedge clk);
    clear = 0;
    chk("clear_hold_valid", out_valid, 0);
    chk("clear_hold_in_ready", in_ready, 1);
    chk("clear_hold_sum", out_sum, 4);

    // async reset mid-frame
    send(4'd3);
    send(4'd3);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_sum", out_sum, 0);
    chk("rst_mid_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send(4'd3);
    expect_res("post_reset", 12, 0, 12, 0);
    take("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
